classic_mode: RTL and testbench

Game-control core for the memory game's classic mode: it sequences pattern generation, waits for the player's guess, compares guess against pattern, and keeps the running score. It sits between the pattern generator (driven by `gen_pattern` / `done_gen_pattern`) and the input handler (supplying `user_guess` / `received_input`). `score` is also the round length fed back to the input handler.

---
 rtl/classic_mode_pkg.sv | 16 +
 rtl/classic_mode_score_counter.sv | 38 +++
 rtl/classic_mode.sv | 82 ++++++++
 tb/tb_classic_mode.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/classic_mode_pkg.sv
// Shared types and default widths for the classic-mode game-control core.
package classic_mode_pkg;

  localparam int unsigned PATTERN_W_DEF = 16;
  localparam int unsigned SCORE_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    WAIT,
    SCORE,
    OVER,
    CLEAR
  } state_e;

endpackage : classic_mode_pkg

// File: rtl/classic_mode_score_counter.sv
// Score counter: synchronous clear with priority over increment, saturating at all-ones.
module score_counter
  import classic_mode_pkg::*;
#(
  parameter int unsigned SCORE_W = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  output logic [SCORE_W-1:0] score
);

  logic [SCORE_W-1:0] count_q;
  logic [SCORE_W-1:0] count_d;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign score = count_q;

endmodule : score_counter

// File: rtl/classic_mode.sv
// Classic-mode game control: sequences pattern generation, guess comparison and scoring.
module classic_mode
  import classic_mode_pkg::*;
#(
  parameter int unsigned PATTERN_W = PATTERN_W_DEF,
  parameter int unsigned SCORE_W   = SCORE_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 done_gen_pattern,
  input  logic                 received_input,
  input  logic                 play_again,
  input  logic [PATTERN_W-1:0] game_pattern,
  input  logic [PATTERN_W-1:0] user_guess,
  output logic                 gen_pattern,
  output logic                 incr_score,
  output logic                 clr,
  output logic                 is_equal,
  output logic [SCORE_W-1:0]   score,
  output logic                 game_over
);

  state_e state_q;
  state_e state_d;

  assign is_equal = received_input && (game_pattern == user_guess);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs; only the transition out of WAIT looks at the comparator.
  always_comb begin
    state_d     = state_q;
    gen_pattern = 1'b0;
    incr_score  = 1'b0;
    clr         = 1'b0;
    game_over   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) state_d = GEN;
      end
      GEN: begin
        gen_pattern = 1'b1;
        if (done_gen_pattern) state_d = WAIT;
      end
      WAIT: begin
        if (received_input) state_d = is_equal ? SCORE : OVER;
      end
      SCORE: begin
        incr_score = 1'b1;
        state_d    = GEN;
      end
      OVER: begin
        game_over = 1'b1;
        if (play_again) state_d = CLEAR;
      end
      CLEAR: begin
        clr     = 1'b1;
        state_d = GEN;
      end
      default: state_d = IDLE;
    endcase
  end

  score_counter #(
    .SCORE_W(SCORE_W)
  ) u_score_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (incr_score),
    .score(score)
  );

endmodule : classic_mode

// File: tb/tb_classic_mode.sv
// Bench for classic_mode: phase-level game model checked every cycle on a 16-bit and a 2-bit score build.
module tb_classic_mode;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done_gen_pattern;
  logic        received_input;
  logic        play_again;
  logic [15:0] game_pattern;
  logic [15:0] user_guess;

  logic        gen_a, incr_a, clr_a, eq_a, over_a;
  logic [15:0] score_a;
  logic        gen_b, incr_b, clr_b, eq_b, over_b;
  logic [1:0]  score_b;

  int n_cmp = 0;
  int n_bad = 0;

  classic_mode #(.PATTERN_W(16), .SCORE_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .done_gen_pattern(done_gen_pattern),
    .received_input(received_input), .play_again(play_again),
    .game_pattern(game_pattern), .user_guess(user_guess),
    .gen_pattern(gen_a), .incr_score(incr_a), .clr(clr_a), .is_equal(eq_a),
    .score(score_a), .game_over(over_a)
  );

  classic_mode #(.PATTERN_W(16), .SCORE_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .done_gen_pattern(done_gen_pattern),
    .received_input(received_input), .play_again(play_again),
    .game_pattern(game_pattern), .user_guess(user_guess),
    .gen_pattern(gen_b), .incr_score(incr_b), .clr(clr_b), .is_equal(eq_b),
    .score(score_b), .game_over(over_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase name plus an unbounded count of won rounds.
  string phase;
  int    wins;
  bit    model_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase    = "idle";
      wins     = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (phase == "idle") begin
        wins = 0;
        if (start) phase = "gen";
      end else if (phase == "gen") begin
        if (done_gen_pattern) phase = "wait";
      end else if (phase == "wait") begin
        if (received_input) phase = (game_pattern == user_guess) ? "score" : "over";
      end else if (phase == "score") begin
        wins++;
        phase = "gen";
      end else if (phase == "over") begin
        if (play_again) phase = "clear";
      end else if (phase == "clear") begin
        wins  = 0;
        phase = "gen";
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && !rst) begin
      logic exp_eq;
      exp_eq = received_input && (game_pattern == user_guess);
      check("gen_pattern", {31'd0, gen_a}, {31'd0, phase == "gen"});
      check("incr_score",  {31'd0, incr_a}, {31'd0, phase == "score"});
      check("clr",         {31'd0, clr_a}, {31'd0, (phase == "idle") || (phase == "clear")});
      check("game_over",   {31'd0, over_a}, {31'd0, phase == "over"});
      check("is_equal",    {31'd0, eq_a}, {31'd0, exp_eq});
      check("score",       {16'd0, score_a}, (wins > 65535) ? 32'd65535 : 32'(wins));
      check("sat_is_equal", {31'd0, eq_b}, {31'd0, exp_eq});
      check("sat_game_over", {31'd0, over_b}, {31'd0, phase == "over"});
      check("sat_score",   {30'd0, score_b}, (wins > 3) ? 32'd3 : 32'(wins));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gen();
    int budget = 20;
    @(negedge clk);
    while (!gen_a && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("wait_gen_timeout", {31'd0, gen_a}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // One round from GEN: generator finishes, then one guess is presented in WAIT.
  task automatic play_round(input logic [15:0] pat, input logic [15:0] gss);
    wait_gen();
    done_gen_pattern = 1'b1;
    step();
    done_gen_pattern = 1'b0;
    game_pattern     = pat;
    user_guess       = gss;
    received_input   = 1'b1;
    @(negedge clk);
    check("round_is_equal", {31'd0, eq_a}, {31'd0, pat == gss});
    step();
    received_input = 1'b0;
    @(negedge clk);
    if (pat == gss) check("round_incr", {31'd0, incr_a}, 32'd1);
    else            check("round_over", {31'd0, over_a}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; done_gen_pattern = 1'b0; received_input = 1'b0;
    play_again = 1'b0; game_pattern = '0; user_guess = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_clr",   {31'd0, clr_a}, 32'd1);
    check("reset_gen",   {31'd0, gen_a}, 32'd0);
    check("reset_score", {16'd0, score_a}, 32'd0);

    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    check("start_gen", {31'd0, gen_a}, 32'd1);

    // Guess offered during GEN: comparator reacts, control does not.
    game_pattern = 16'h0016; user_guess = 16'h0016; received_input = 1'b1;
    @(negedge clk);
    check("gen_ignore_eq", {31'd0, eq_a}, 32'd1);
    step();
    received_input = 1'b0;
    @(negedge clk);
    check("gen_ignore_stay", {31'd0, gen_a}, 32'd1);
    check("gen_ignore_score", {16'd0, score_a}, 32'd0);

    // play_again with done_gen_pattern held in WAIT must both be ignored.
    wait_gen();
    done_gen_pattern = 1'b1;
    step();
    play_again = 1'b1;
    step();
    play_again = 1'b0;
    done_gen_pattern = 1'b0;
    @(negedge clk);
    check("wait_ignore_gen", {31'd0, gen_a}, 32'd0);
    check("wait_ignore_over", {31'd0, over_a}, 32'd0);
    received_input = 1'b1;
    step();
    received_input = 1'b0;
    step();
    @(negedge clk);
    check("round1_score", {16'd0, score_a}, 32'd1);

    play_round(16'h0016, 16'h0016);
    play_round(16'h0016, 16'h0016);
    step();
    @(negedge clk);
    check("three_rounds_score", {16'd0, score_a}, 32'd3);

    play_round(16'h0017, 16'h0016);
    repeat (3) step();
    @(negedge clk);
    check("over_held", {31'd0, over_a}, 32'd1);
    check("over_score", {16'd0, score_a}, 32'd3);

    play_again = 1'b1;
    step();
    play_again = 1'b0;
    @(negedge clk);
    check("clear_clr", {31'd0, clr_a}, 32'd1);
    step();
    @(negedge clk);
    check("restart_gen", {31'd0, gen_a}, 32'd1);
    check("restart_score", {16'd0, score_a}, 32'd0);

    for (int r = 0; r < 4; r++) play_round(16'hA5C3, 16'hA5C3);
    step();
    @(negedge clk);
    check("wide_score_4", {16'd0, score_a}, 32'd4);
    check("sat_score_held", {30'd0, score_b}, 32'd3);

    wait_gen();
    done_gen_pattern = 1'b1;
    step();
    done_gen_pattern = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midgame_rst_clr", {31'd0, clr_a}, 32'd1);
    check("midgame_rst_score", {16'd0, score_a}, 32'd0);
    check("midgame_rst_sat", {30'd0, score_b}, 32'd0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_classic_mode
